// File: rtl/mips_dmem_pkg.sv
// Shared constants and types for the MA-stage data memory bridge:
// MMIO address map, STATUS bit positions and the UART transmitter state type.
package mips_dmem_pkg;

   localparam logic [7:0] ADDR_TXDATA = 8'hF0;
   localparam logic [7:0] ADDR_STATUS = 8'hF1;
   localparam logic [7:0] ADDR_CYCCNT = 8'hF2;
   localparam logic [7:0] ADDR_LED    = 8'hF3;

   localparam int STAT_FULL  = 0;
   localparam int STAT_EMPTY = 1;
   localparam int STAT_BUSY  = 2;
   localparam int STAT_OVF   = 3;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

endpackage

// File: rtl/dmem_uart_tx.sv
// UART transmit path: byte FIFO feeding an 8N1 serializer.
// state    | meaning
// TX_IDLE  | line high; pops the FIFO head when one is waiting
// TX_START | start bit (low) for BAUD_DIV cycles
// TX_DATA  | 8 data bits, LSB first, BAUD_DIV cycles each
// TX_STOP  | stop bit (high) for BAUD_DIV cycles
module dmem_uart_tx
   import mips_dmem_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int BAUD_DIV   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] push_data,
   output logic       full,
   output logic       empty,
   output logic       busy,
   output logic       uart_tx
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(BAUD_DIV);
   localparam logic [PW:0]   DEPTH_CNT = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [BW-1:0] BAUD_LOAD = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;

   tx_state_t     state;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;

   logic push_ok;
   logic pop;

   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign busy    = (state != TX_IDLE);
   assign push_ok = push && !full;
   assign pop     = (state == TX_IDLE) && !empty;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr] <= push_data;
      end
   end

   // Fullness is judged on the start-of-cycle count, so a same-cycle pop never rescues a push.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         unique case ({push_ok, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= TX_IDLE;
         uart_tx   <= 1'b1;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         unique case (state)
            TX_IDLE: begin
               uart_tx <= 1'b1;
               if (!empty) begin
                  shift_reg <= fifo_mem[rd_ptr];
                  baud_cnt  <= BAUD_LOAD;
                  uart_tx   <= 1'b0;
                  state     <= TX_START;
               end
            end
            TX_START: begin
               if (baud_cnt == '0) begin
                  baud_cnt <= BAUD_LOAD;
                  bit_cnt  <= '0;
                  uart_tx  <= shift_reg[0];
                  state    <= TX_DATA;
               end else begin
                  baud_cnt <= baud_cnt - BAUD_ONE;
               end
            end
            TX_DATA: begin
               if (baud_cnt == '0) begin
                  baud_cnt <= BAUD_LOAD;
                  if (bit_cnt == 3'd7) begin
                     uart_tx <= 1'b1;
                     state   <= TX_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     uart_tx <= shift_reg[bit_cnt + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt - BAUD_ONE;
               end
            end
            TX_STOP: begin
               if (baud_cnt == '0) begin
                  state <= TX_IDLE;
               end else begin
                  baud_cnt <= baud_cnt - BAUD_ONE;
               end
            end
            default: begin
               state   <= TX_IDLE;
               uart_tx <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/mips_dmem_bridge.sv
// Data-side memory bridge behind the core's MA stage: byte RAM, UART TX, STATUS, LED.
// Define DMEM_CYCCNT_EN to add the free-running 8-bit cycle counter at CYCCNT.
module mips_dmem_bridge
   import mips_dmem_pkg::*;
#(
   parameter int RAM_DEPTH  = 240,
   parameter int FIFO_DEPTH = 4,
   parameter int BAUD_DIV   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       breq,
   input  logic       mem_w_en,
   input  logic [7:0] mem_rw_addr,
   input  logic [7:0] mem_w,
   output logic [7:0] mem_r,
   output logic       uart_tx,
   output logic [7:0] led
);

   localparam int RAW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam logic [8:0] RAM_LIMIT = 9'(RAM_DEPTH);

   logic [7:0]     ram [RAM_DEPTH];
   logic [RAW-1:0] ram_idx;
   logic           in_ram;
   logic           store;
   logic           load;
   logic           tx_push;
   logic           fifo_full;
   logic           fifo_empty;
   logic           tx_busy;
   logic           overflow;
   logic [7:0]     status;
   logic [7:0]     cyc_val;
   logic [7:0]     rd_data;

   assign store   = breq && mem_w_en;
   assign load    = breq && !mem_w_en;
   assign in_ram  = ({1'b0, mem_rw_addr} < RAM_LIMIT);
   assign ram_idx = mem_rw_addr[RAW-1:0];
   assign tx_push = store && (mem_rw_addr == ADDR_TXDATA);

   dmem_uart_tx #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .BAUD_DIV   (BAUD_DIV)
   ) u_uart_tx (
      .clk       (clk),
      .rst       (rst),
      .push      (tx_push),
      .push_data (mem_w),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .busy      (tx_busy),
      .uart_tx   (uart_tx)
   );

   always_ff @(posedge clk) begin
      if (!rst && store && in_ram) begin
         ram[ram_idx] <= mem_w;
      end
   end

   // A dropped push and a clear in the same cycle leave the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (tx_push && fifo_full) begin
         overflow <= 1'b1;
      end else if (store && (mem_rw_addr == ADDR_STATUS) && mem_w[STAT_OVF]) begin
         overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led <= '0;
      end else if (store && (mem_rw_addr == ADDR_LED)) begin
         led <= mem_w;
      end
   end

`ifdef DMEM_CYCCNT_EN
   logic [7:0] cyc_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_cnt <= '0;
      end else begin
         cyc_cnt <= cyc_cnt + 8'd1;
      end
   end

   assign cyc_val = cyc_cnt;
`else
   assign cyc_val = 8'h00;
`endif

   always_comb begin
      status             = '0;
      status[STAT_FULL]  = fifo_full;
      status[STAT_EMPTY] = fifo_empty;
      status[STAT_BUSY]  = tx_busy;
      status[STAT_OVF]   = overflow;
   end

   always_comb begin
      rd_data = '0;
      if (in_ram) begin
         rd_data = ram[ram_idx];
      end else begin
         unique case (mem_rw_addr)
            ADDR_STATUS: rd_data = status;
            ADDR_CYCCNT: rd_data = cyc_val;
            ADDR_LED:    rd_data = led;
            default:     rd_data = '0;
         endcase
      end
   end

   // Load data is held for exactly one cycle; any cycle not following a load reads zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_r <= '0;
      end else begin
         mem_r <= load ? rd_data : 8'h00;
      end
   end

endmodule
